// File: rtl/dsp_sys_arr_pkg.sv
// Shared types and defaults for the systolic-array datapath; hosts the fifo_mc
// error-flag struct, default geometry and the occupancy-width helper.
package dsp_sys_arr_pkg;

  localparam int FIFO_MC_DEF_DEPTH = 16;
  localparam int FIFO_MC_DEF_BW    = 2;

  typedef struct packed {
    logic ovf;
    logic udf;
  } fifo_err_t;

  // Occupancy must represent 0..depth inclusive.
  function automatic int ocp_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_mc_if.sv
// Push/pop data and status bundle of fifo_mc. The slave modport is the FIFO side;
// the master modport is the producer/consumer side.
interface fifo_mc_if
  import dsp_sys_arr_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BW    = FIFO_MC_DEF_BW,
  parameter int DEPTH = FIFO_MC_DEF_DEPTH
);

  logic                      push;
  logic                      pop;
  logic [BW*WIDTH-1:0]       dat_in;
  logic [BW*WIDTH-1:0]       dat_out;
  logic [ocp_w(DEPTH)-1:0]   ocp;
  logic                      is_full;
  logic                      is_empty;
  logic                      almost_full;
  logic                      almost_empty;

  modport master (
    output push, pop, dat_in,
    input  dat_out, ocp, is_full, is_empty, almost_full, almost_empty
  );

  modport slave (
    input  push, pop, dat_in,
    output dat_out, ocp, is_full, is_empty, almost_full, almost_empty
  );

endinterface

// File: rtl/wrap_ptr.sv
// Wrap-around index counter 0..DEPTH-1 using an explicit end compare, so any
// DEPTH >= 2 wraps correctly without a modulo.
module wrap_ptr #(
  parameter int DEPTH = 16,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          RST,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (RST) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_mc.sv
// Multi-lane show-ahead FIFO with arbitrary depth, almost-full/empty thresholds,
// flush and sticky error flags. Define FIFO_MC_HWM_EN to enable the high-water mark.
module fifo_mc
  import dsp_sys_arr_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int BW        = FIFO_MC_DEF_BW,
  parameter int DEPTH     = FIFO_MC_DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1,
  localparam int EW       = BW * WIDTH,
  localparam int OW       = ocp_w(DEPTH),
  localparam int PW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          RST,
  input  logic          flush,
  input  logic          err_clr,
  fifo_mc_if.slave      bus,
  output logic          ovf,
  output logic          udf,
  output logic [OW-1:0] hwm
);

  if (DEPTH < 2 || AF_THRESH > DEPTH || AE_THRESH >= DEPTH) begin : g_bad_param
    $fatal(1, "fifo_mc: illegal DEPTH/AF_THRESH/AE_THRESH combination");
  end

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [OW-1:0] ocp_q, ocp_d;
  fifo_err_t     err_q, err_d;
  logic [PW-1:0] w_ptr, r_ptr;
  logic          is_full, is_empty;
  logic          pop_ok, push_ok, wr_en, rd_en;

  assign is_full  = (ocp_q == OW'(DEPTH));
  assign is_empty = (ocp_q == '0);
  assign pop_ok   = bus.pop & ~is_empty;
  assign push_ok  = bus.push & (~is_full | pop_ok);
  assign wr_en    = push_ok & ~flush;
  assign rd_en    = pop_ok & ~flush;

  wrap_ptr #(.DEPTH(DEPTH)) u_w_ptr (
    .clk (clk), .RST (RST), .clr (flush), .inc (wr_en), .ptr (w_ptr)
  );

  wrap_ptr #(.DEPTH(DEPTH)) u_r_ptr (
    .clk (clk), .RST (RST), .clr (flush), .inc (rd_en), .ptr (r_ptr)
  );

  // A popped slot is zeroed; a write to the same slot in that cycle wins.
  always_comb begin
    mem_d = mem_q;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
    end else begin
      if (rd_en) mem_d[r_ptr] = '0;
      if (wr_en) mem_d[w_ptr] = bus.dat_in;
    end
  end

  always_comb begin
    if (flush) ocp_d = '0;
    else       ocp_d = ocp_q + OW'(wr_en) - OW'(rd_en);
  end

  // Flush suppresses error detection but leaves existing flags alone.
  always_comb begin
    err_d = err_q;
    if (err_clr) err_d = '0;
    if (bus.push & is_full & ~pop_ok & ~flush) err_d.ovf = 1'b1;
    if (bus.pop & is_empty & ~flush)           err_d.udf = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      ocp_q <= '0;
      err_q <= '0;
    end else begin
      mem_q <= mem_d;
      ocp_q <= ocp_d;
      err_q <= err_d;
    end
  end

`ifdef FIFO_MC_HWM_EN
  logic [OW-1:0] hwm_q, hwm_d;

  always_comb begin
    hwm_d = hwm_q;
    if (flush | err_clr)    hwm_d = '0;
    else if (ocp_d > hwm_q) hwm_d = ocp_d;
  end

  always_ff @(posedge clk) begin
    if (RST) hwm_q <= '0;
    else     hwm_q <= hwm_d;
  end

  assign hwm = hwm_q;
`else
  assign hwm = '0;
`endif

  assign bus.dat_out      = is_empty ? '0 : mem_q[r_ptr];
  assign bus.ocp          = ocp_q;
  assign bus.is_full      = is_full;
  assign bus.is_empty     = is_empty;
  assign bus.almost_full  = (ocp_q >= OW'(AF_THRESH));
  assign bus.almost_empty = (ocp_q <= OW'(AE_THRESH));
  assign ovf              = err_q.ovf;
  assign udf              = err_q.udf;

endmodule

// File: doc/fifo_mc.md
Name: fifo_mc

Overview:
- Parametrised successor to the single-width circular FIFO in the systolic-array datapath; buffers BW-lane operand vectors between the DSP array and the load/drain stages.
- Generalised over word width, lane count and arbitrary (non-power-of-2) depth.
- Adds programmable almost-full/almost-empty thresholds, synchronous flush, and sticky overflow/underflow error flags.
- Show-ahead read: head entry is visible on dat_out before pop.

Parameters:
- WIDTH, 16, bits per lane word
- BW, 2, lanes per entry; entry width = BW*WIDTH
- DEPTH, 16, number of entries; any value >= 2, not restricted to powers of 2
- AF_THRESH, DEPTH-2, almost_full asserts when ocp >= AF_THRESH
- AE_THRESH, 1, almost_empty asserts when ocp <= AE_THRESH

Ports:
- clk  in  1  rising-edge clock
- RST  in  1  synchronous, active-high reset
- flush  in  1  synchronous clear of contents and pointers
- push  in  1  write request
- dat_in  in  BW*WIDTH  write data, lane 0 in LSBs
- pop  in  1  read/advance request
- dat_out  out  BW*WIDTH  head entry; 0 when empty
- ocp  out  $clog2(DEPTH+1)  occupancy
- is_full  out  1  ocp == DEPTH
- is_empty  out  1  ocp == 0
- almost_full  out  1  ocp >= AF_THRESH
- almost_empty  out  1  ocp <= AE_THRESH
- ovf  out  1  sticky: push was dropped
- udf  out  1  sticky: pop was rejected
- err_clr  in  1  clears ovf/udf
- hwm  out  $clog2(DEPTH+1)  high-water mark (see Optional Feature)

Behaviour:
- Single clock domain. RST is sampled only on posedge clk and takes priority over all other inputs.
- RST values: storage all 0, w_ptr = r_ptr = 0, ocp = 0, ovf = udf = 0, hwm = 0. Consequently dat_out = 0, is_empty = 1, is_full = 0, almost_empty = 1, almost_full = (AF_THRESH == 0).
- Status outputs (is_full, is_empty, almost_*) are combinational from registered ocp. dat_out = is_empty ? 0 : mem[r_ptr].
- Acceptance:
  - pop_ok = pop & ~is_empty
  - push_ok = push & (~is_full | pop_ok)
- Simultaneous push and pop:
  - empty: push only; ocp +1; pop rejected, udf set.
  - full: both accepted; ocp unchanged; new data written at w_ptr (slot freed by pop this cycle).
  - otherwise: both accepted; ocp unchanged.
- Write latency: a pushed entry is visible on dat_out the next cycle if the FIFO was empty. No combinational bypass from dat_in to dat_out.
- On pop_ok, mem[r_ptr] is cleared to 0 unless the same slot is written that cycle (write wins).
- Pointer wrap: explicit compare, ptr == DEPTH-1 -> 0, else ptr + 1. No modulo operator, so non-power-of-2 DEPTH is correct.
- ocp arithmetic is at $clog2(DEPTH+1) width and never exceeds DEPTH or goes below 0.
- flush: next cycle pointers = 0, ocp = 0, storage = 0. Push/pop in the same cycle are ignored and do not set ovf/udf. ovf/udf are not cleared by flush.
- Error flags:
  - ovf sets on push & is_full & ~pop_ok.
  - udf sets on pop & is_empty.
  - Both hold until err_clr or RST; a set event in the same cycle as err_clr wins.
- Parameter check: elaboration fatal if DEPTH < 2, AF_THRESH > DEPTH, or AE_THRESH >= DEPTH.

Optional Feature:
- Macro: FIFO_MC_HWM_EN.
- Defined: hwm register tracks max(ocp) reached. Updated each cycle as hwm <= max(hwm, n_ocp). Cleared to 0 by RST, flush or err_clr.
- Undefined: no hwm register; hwm port tied to 0. Port list is identical in both builds.

Decomposition:
- Add to dsp_sys_arr_pkg:
  - fifo_err_t packed struct {ovf, udf}
  - FIFO_MC_DEF_DEPTH = 16
  - FIFO_MC_DEF_BW = 2
  - function ocp_w(depth) returning $clog2(depth+1)
- Sub-module wrap_ptr (parameter DEPTH; inputs clk, RST, clr, inc; output ptr): wrap-around counter, instantiated twice for w_ptr and r_ptr.

Test Plan:
- DEPTH=5, BW=2, WIDTH=16: reset, push 5 entries 0x0001_0000..0x0005_0004 -> is_full=1 and ocp=5 after the 5th edge; 6th push -> ovf=1, ocp stays 5, contents unchanged.
- Full, push 0xAAAA_BBBB and pop same cycle -> ocp stays 5; dat_out = 0x0002_0001; after 4 more pops, dat_out = 0xAAAA_BBBB, verifying slot-4 -> slot-0 wrap.
- Empty, push 0x1234_5678 and pop same cycle -> ocp=1, udf=1, dat_out = 0x1234_5678 next cycle; err_clr -> udf=0 next cycle.
- DEPTH=5, AF_THRESH=4, AE_THRESH=1: step ocp 0..5 -> almost_empty high at ocp 0-1, almost_full high at ocp 4-5.
- ocp=3, flush with push=1 -> next cycle ocp=0, is_empty=1, dat_out=0, ovf unchanged; RST mid-stream at ocp=2 -> all outputs at reset values next cycle.
- FIFO_MC_HWM_EN defined: push 4, pop 3, push 1 -> hwm=4; flush -> hwm=0. Undefined: hwm=0 throughout.
